// File: rtl/axi_aw_arb3.sv
// Three-port AXI AW arbiter and channel mux with registered output slice and grant-order tracking.
// Optional grant-order FIFO is enabled by defining AXI_AW_ARB3_ORDER_FIFO_EN.
`timescale 1ns/1ps
module axi_aw_arb3 #(
  parameter int unsigned AW        = 32,
  parameter int unsigned IDW       = 4,
  parameter int unsigned ORD_DEPTH = 8
) (
  input  logic           aclk,
  input  logic           areset,
  input  logic           arb_en,
  input  logic [1:0]     arb_mode,
  input  logic [15:0]    weight0,
  input  logic [15:0]    weight1,
  input  logic [15:0]    weight2,
  input  logic           s0_awvalid,
  output logic           s0_awready,
  input  logic [AW-1:0]  s0_awaddr,
  input  logic [IDW-1:0] s0_awid,
  input  logic [7:0]     s0_awlen,
  input  logic           s1_awvalid,
  output logic           s1_awready,
  input  logic [AW-1:0]  s1_awaddr,
  input  logic [IDW-1:0] s1_awid,
  input  logic [7:0]     s1_awlen,
  input  logic           s2_awvalid,
  output logic           s2_awready,
  input  logic [AW-1:0]  s2_awaddr,
  input  logic [IDW-1:0] s2_awid,
  input  logic [7:0]     s2_awlen,
  output logic           m_awvalid,
  input  logic           m_awready,
  output logic [AW-1:0]  m_awaddr,
  output logic [IDW-1:0] m_awid,
  output logic [7:0]     m_awlen,
  output logic [1:0]     m_awsrc,
  output logic           wsel_valid,
  output logic [1:0]     wsel,
  input  logic           wsel_pop
);

  localparam int unsigned CNTW = 17;
  localparam logic [1:0]  MODE_RR  = 2'd1;
  localparam logic [1:0]  MODE_WGT = 2'd2;

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic [IDW-1:0] id;
    logic [7:0]     len;
  } aw_pl_t;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  logic            m_awvalid_q;
  aw_pl_t          m_pl_q;
  logic [1:0]      m_awsrc_q;
  logic [1:0]      last_q, last_d;
  logic [CNTW-1:0] run_cnt_q, run_cnt_d;
  logic            en_prev_q;
  logic [1:0]      mode_prev_q;

  logic            can_load_c;
  logic [2:0]      req_c;
  logic [1:0]      fix_idx_c, rr_idx_c, pick_c;
  logic [1:0]      rr_c0, rr_c1, rr_c2;
  logic [15:0]     cur_w_c;
  logic            hold_c;
  logic            grant_c;
  logic            cfg_chg_c;
  aw_pl_t          pick_pl_c;

  // Request vector: ports 1 and 2 are masked off while arbitration is disabled
  always_comb begin
    req_c = {s2_awvalid & arb_en, s1_awvalid & arb_en, s0_awvalid};

    fix_idx_c = 2'd2;
    if (req_c[0])      fix_idx_c = 2'd0;
    else if (req_c[1]) fix_idx_c = 2'd1;

    rr_c0    = inc3(last_q);
    rr_c1    = inc3(rr_c0);
    rr_c2    = inc3(rr_c1);
    rr_idx_c = rr_c2;
    if (req_c[rr_c0])      rr_idx_c = rr_c0;
    else if (req_c[rr_c1]) rr_idx_c = rr_c1;

    case (last_q)
      2'd0:    cur_w_c = weight0;
      2'd1:    cur_w_c = weight1;
      default: cur_w_c = weight2;
    endcase
    hold_c = req_c[last_q] & (run_cnt_q <= CNTW'(cur_w_c));

    case (arb_mode)
      MODE_RR:  pick_c = rr_idx_c;
      MODE_WGT: pick_c = hold_c ? last_q : rr_idx_c;
      default:  pick_c = fix_idx_c;
    endcase
    if (!arb_en) pick_c = 2'd0;

    grant_c = can_load_c & (|req_c);
  end

  assign s0_awready = grant_c & (pick_c == 2'd0);
  assign s1_awready = grant_c & (pick_c == 2'd1);
  assign s2_awready = grant_c & (pick_c == 2'd2);

  always_comb begin
    case (pick_c)
      2'd0:    pick_pl_c = '{addr: s0_awaddr, id: s0_awid, len: s0_awlen};
      2'd1:    pick_pl_c = '{addr: s1_awaddr, id: s1_awid, len: s1_awlen};
      default: pick_pl_c = '{addr: s2_awaddr, id: s2_awid, len: s2_awlen};
    endcase
  end

  // Config samplers run through reset so a config held across reset is not seen as a change
  always_ff @(posedge aclk) begin
    en_prev_q   <= arb_en;
    mode_prev_q <= arb_mode;
  end
  assign cfg_chg_c = (arb_en != en_prev_q) | (arb_mode != mode_prev_q);

  always_comb begin
    last_d    = last_q;
    run_cnt_d = run_cnt_q;
    if (grant_c) begin
      last_d = pick_c;
      if (pick_c == last_q) run_cnt_d = (&run_cnt_q) ? run_cnt_q : run_cnt_q + CNTW'(1);
      else                  run_cnt_d = CNTW'(1);
    end
    if (cfg_chg_c) run_cnt_d = '0;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      last_q    <= 2'd2;
      run_cnt_q <= '0;
    end else begin
      last_q    <= last_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  // Output register slice
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_awvalid_q <= 1'b0;
      m_pl_q      <= '0;
      m_awsrc_q   <= 2'd0;
    end else if (grant_c) begin
      m_awvalid_q <= 1'b1;
      m_pl_q      <= pick_pl_c;
      m_awsrc_q   <= pick_c;
    end else if (m_awready) begin
      m_awvalid_q <= 1'b0;
    end
  end

  assign m_awvalid = m_awvalid_q;
  assign m_awaddr  = m_pl_q.addr;
  assign m_awid    = m_pl_q.id;
  assign m_awlen   = m_pl_q.len;
  assign m_awsrc   = m_awsrc_q;

`ifdef AXI_AW_ARB3_ORDER_FIFO_EN
  localparam int unsigned PW = $clog2(ORD_DEPTH) + 1;

  logic [1:0]    ord_mem [ORD_DEPTH];
  logic [PW-1:0] wr_q, rd_q, wr_d, rd_d;
  logic          wsel_valid_q, wsel_valid_d;
  logic [1:0]    wsel_q, wsel_d;
  logic          full_c, push_c, pop_c;

  assign full_c     = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[PW-2:0] == rd_q[PW-2:0]);
  assign can_load_c = (!m_awvalid_q | m_awready) & !full_c;
  assign push_c     = grant_c;
  assign pop_c      = wsel_pop & wsel_valid_q;

  // Head register tracks the post-update FIFO state; a push into an empty slot bypasses the RAM
  always_comb begin
    wr_d         = wr_q + PW'(push_c);
    rd_d         = rd_q + PW'(pop_c);
    wsel_valid_d = (wr_d != rd_d);
    if (push_c && (rd_d[PW-2:0] == wr_q[PW-2:0])) wsel_d = pick_c;
    else                                          wsel_d = ord_mem[rd_d[PW-2:0]];
  end

  always_ff @(posedge aclk) begin
    if (push_c) ord_mem[wr_q[PW-2:0]] <= pick_c;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_q         <= '0;
      rd_q         <= '0;
      wsel_valid_q <= 1'b0;
      wsel_q       <= 2'd0;
    end else begin
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      wsel_valid_q <= wsel_valid_d;
      wsel_q       <= wsel_d;
    end
  end

  assign wsel_valid = wsel_valid_q;
  assign wsel       = wsel_q;
`else
  logic unused_wsel_pop;

  assign can_load_c      = !m_awvalid_q | m_awready;
  assign wsel_valid      = 1'b0;
  assign wsel            = 2'd0;
  assign unused_wsel_pop = wsel_pop;
`endif

endmodule

// File: tb/tb_axi_aw_arb3.sv
// Scoreboard bench for axi_aw_arb3: stimulus queues expected grant sources, a negedge monitor checks master beats.
`timescale 1ns/1ps
module tb_axi_aw_arb3;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        arb_en = 1'b1;
  logic [1:0]  arb_mode = 2'd0;
  logic [15:0] weight0 = '0, weight1 = '0, weight2 = '0;
  logic        s0_awvalid = 1'b0, s1_awvalid = 1'b0, s2_awvalid = 1'b0;
  logic        s0_awready, s1_awready, s2_awready;
  logic        m_awvalid;
  logic        m_awready = 1'b1;
  logic [31:0] m_awaddr;
  logic [3:0]  m_awid;
  logic [7:0]  m_awlen;
  logic [1:0]  m_awsrc;
  logic        wsel_valid;
  logic [1:0]  wsel;
  logic        wsel_pop = 1'b0;

  localparam logic [31:0] ADDR [3] = '{32'h1000_0A00, 32'h2000_0B40, 32'h3000_0C80};
  localparam logic [3:0]  ID   [3] = '{4'h5, 4'h9, 4'hC};
  localparam logic [7:0]  LEN  [3] = '{8'h03, 8'h0F, 8'hFF};

  int         n_cmp = 0;
  int         n_err = 0;
  logic [1:0] exp_q[$];
  logic       en_off_chk = 1'b0;

  always #5 aclk = ~aclk;

  axi_aw_arb3 #(.AW(32), .IDW(4), .ORD_DEPTH(8)) dut (
    .aclk(aclk), .areset(areset), .arb_en(arb_en), .arb_mode(arb_mode),
    .weight0(weight0), .weight1(weight1), .weight2(weight2),
    .s0_awvalid(s0_awvalid), .s0_awready(s0_awready), .s0_awaddr(ADDR[0]), .s0_awid(ID[0]), .s0_awlen(LEN[0]),
    .s1_awvalid(s1_awvalid), .s1_awready(s1_awready), .s1_awaddr(ADDR[1]), .s1_awid(ID[1]), .s1_awlen(LEN[1]),
    .s2_awvalid(s2_awvalid), .s2_awready(s2_awready), .s2_awaddr(ADDR[2]), .s2_awid(ID[2]), .s2_awlen(LEN[2]),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen),
    .m_awsrc(m_awsrc), .wsel_valid(wsel_valid), .wsel(wsel), .wsel_pop(wsel_pop)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every master handshake must match the head of the expected queue
  always @(negedge aclk) begin
    if (!areset) begin
      chk("awready_onehot", 64'($countones({s2_awready, s1_awready, s0_awready}) <= 1), 64'd1);
      if (en_off_chk) chk("en_off_s12_ready", 64'(s1_awready | s2_awready), 64'd0);
      if (m_awvalid && m_awready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat_src", 64'(m_awsrc), 64'hF);
        end else begin
          automatic logic [1:0] p = exp_q.pop_front();
          chk("beat_src", 64'(m_awsrc), 64'(p));
          chk("beat_addr", 64'(m_awaddr), 64'(ADDR[p]));
          chk("beat_id", 64'(m_awid), 64'(ID[p]));
          chk("beat_len", 64'(m_awlen), 64'(LEN[p]));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic set_valid(input logic [2:0] v);
    s0_awvalid = v[0];
    s1_awvalid = v[1];
    s2_awvalid = v[2];
  endtask

  task automatic push_exp(input logic [1:0] p, input int n);
    repeat (n) exp_q.push_back(p);
  endtask

  task automatic do_reset(input logic en, input logic [1:0] mode);
    areset = 1'b1;
    set_valid(3'b000);
    m_awready = 1'b1;
    wsel_pop  = 1'b0;
    arb_en    = en;
    arb_mode  = mode;
    tick(3);
    areset = 1'b0;
    tick(2);
  endtask

  task automatic drain(input string name);
    set_valid(3'b000);
    m_awready = 1'b1;
    tick(4);
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    tick(2);
    @(negedge aclk);
    chk("rst_m_awvalid", 64'(m_awvalid), 64'd0);
    chk("rst_m_awaddr", 64'(m_awaddr), 64'd0);
    chk("rst_m_awid", 64'(m_awid), 64'd0);
    chk("rst_m_awlen", 64'(m_awlen), 64'd0);
    chk("rst_m_awsrc", 64'(m_awsrc), 64'd0);
    chk("rst_wsel_valid", 64'(wsel_valid), 64'd0);
    chk("rst_wsel", 64'(wsel), 64'd0);

    // Fixed priority: port 0 wins, then port 1 beats port 2
    do_reset(1'b1, 2'd0);
    push_exp(2'd0, 6);
    set_valid(3'b111);
    tick(6);
    push_exp(2'd1, 4);
    set_valid(3'b110);
    tick(4);
    drain("fixed_drain");

    // Mode 3 behaves as fixed priority
    do_reset(1'b1, 2'd3);
    push_exp(2'd0, 3);
    set_valid(3'b111);
    tick(3);
    drain("mode3_drain");

    // Round robin from reset
    do_reset(1'b1, 2'd1);
    for (int i = 0; i < 3; i++) begin
      push_exp(2'd0, 1);
      push_exp(2'd1, 1);
      push_exp(2'd2, 1);
    end
    set_valid(3'b111);
    tick(9);
    drain("rr_drain");

    // Weighted 2/0/1: last=2 with run_cnt=0 holds twice, then steady 0,0,0,1,2,2
    do_reset(1'b1, 2'd2);
    weight0 = 16'd2;
    weight1 = 16'd0;
    weight2 = 16'd1;
    tick(2);
    push_exp(2'd2, 2);
    for (int i = 0; i < 2; i++) begin
      push_exp(2'd0, 3);
      push_exp(2'd1, 1);
      push_exp(2'd2, 2);
    end
    push_exp(2'd0, 3);
    set_valid(3'b111);
    tick(17);
    // Lone requester keeps winning past its quota
    push_exp(2'd1, 3);
    set_valid(3'b010);
    tick(3);
    drain("wgt_drain");

    // Arbitration disabled: only port 0 is served
    do_reset(1'b0, 2'd1);
    en_off_chk = 1'b1;
    push_exp(2'd0, 6);
    set_valid(3'b111);
    tick(6);
    drain("en_off_drain");
    en_off_chk = 1'b0;

    // Slice stall: held payload, no slave ready
    do_reset(1'b1, 2'd0);
    m_awready = 1'b0;
    push_exp(2'd1, 1);
    set_valid(3'b010);
    tick(1);
    set_valid(3'b101);
    repeat (5) begin
      @(negedge aclk);
      chk("stall_valid", 64'(m_awvalid), 64'd1);
      chk("stall_addr", 64'(m_awaddr), 64'(ADDR[1]));
      chk("stall_src", 64'(m_awsrc), 64'd1);
      chk("stall_ready", 64'({s2_awready, s1_awready, s0_awready}), 64'd0);
      tick(1);
    end
`ifdef AXI_AW_ARB3_ORDER_FIFO_EN
    // Order FIFO fills to 8 entries, then one pop admits exactly one more grant
    m_awready = 1'b1;
    set_valid(3'b001);
    push_exp(2'd0, 7);
    tick(12);
    @(negedge aclk);
    chk("fifo_full_valid", 64'(wsel_valid), 64'd1);
    chk("fifo_head", 64'(wsel), 64'd1);
    chk("fifo_full_stall", 64'(s0_awready), 64'd0);
    tick(1);
    wsel_pop = 1'b1;
    push_exp(2'd0, 1);
    tick(1);
    wsel_pop = 1'b0;
    @(negedge aclk);
    chk("fifo_after_pop_head", 64'(wsel), 64'd0);
    tick(3);
    drain("fifo_drain");
`else
    set_valid(3'b000);
    m_awready = 1'b1;
    tick(1);
    drain("stall_drain");
    chk("nofifo_wsel_valid", 64'(wsel_valid), 64'd0);
`endif

    // Reset mid-transfer with a held beat and three recorded grants
    do_reset(1'b1, 2'd1);
    push_exp(2'd0, 1);
    push_exp(2'd1, 1);
    set_valid(3'b111);
    tick(3);
    set_valid(3'b000);
    m_awready = 1'b0;
    @(negedge aclk);
    chk("pre_rst_valid", 64'(m_awvalid), 64'd1);
    chk("pre_rst_src", 64'(m_awsrc), 64'd2);
`ifdef AXI_AW_ARB3_ORDER_FIFO_EN
    chk("pre_rst_wsel_valid", 64'(wsel_valid), 64'd1);
    chk("pre_rst_wsel", 64'(wsel), 64'd0);
`endif
    #2;
    areset = 1'b1;
    set_valid(3'b111);
    m_awready = 1'b1;
    #1;
    chk("rst_async_valid", 64'(m_awvalid), 64'd0);
    tick(1);
    chk("rst_next_valid", 64'(m_awvalid), 64'd0);
    chk("rst_next_wsel_valid", 64'(wsel_valid), 64'd0);
    tick(1);
    areset = 1'b0;
    push_exp(2'd0, 1);
    tick(1);
    drain("rst_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
